// File: rtl/i2c_master_fsm.sv
// i2c_master_fsm: single-byte I2C register write/read master.
// SCL is generated from the system clock, with each bit split into four quarters of QTR_CNT clocks.
// Optional feature: define I2C_CLK_STRETCH_EN to honour slave clock stretching on released SCL.
module i2c_master_fsm #(
    parameter int QTR_CNT = 250
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       start_in,
    input  logic       rw_in,
    input  logic [6:0] dev_addr_in,
    input  logic [7:0] reg_addr_in,
    input  logic [7:0] wr_data_in,
    output logic [7:0] rd_data_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       ack_err_out,
    inout  wire        i2c_scl,
    inout  wire        i2c_sda
);

    localparam int QW = $clog2(QTR_CNT);
    localparam logic [QW-1:0] QLAST = QW'(QTR_CNT - 1);
`ifdef I2C_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_ACK_A, S_REG, S_ACK_R, S_WDATA, S_ACK_D,
        S_RSTART, S_ADDR_R, S_ACK_A2, S_RDATA, S_MNACK, S_STOP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic          rw_q, rw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d, wd_q, wd_d;
    logic [7:0]    rx_q, rx_d, rd_q, rd_d;
    logic          err_q, err_d, nack_q, nack_d;
    logic          scl_low_q, sda_pre_q, sda_low_q;
    logic          scl_low_c, sda_low_c;
    logic [7:0]    tx_byte;
    logic          stall, tick, last_q, sample;

    // Open-drain pins: only ever pull low or release.
    assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

    assign rd_data_out = rd_q;
    assign ack_err_out = err_q;
    assign busy_out    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_out    = (state_q == S_DONE);

    // A slave holding SCL low after we released it freezes the quarter counter.
    assign stall  = STRETCH && !scl_low_q && (i2c_scl == 1'b0);
    assign tick   = (qcnt_q == QLAST) && !stall;
    assign sample = tick && (qtr_q == 2'd2);

    // Last quarter of the current phase: START has 2 quarters, Sr/STOP 3, bit slots 4.
    always_comb begin
        last_q = (qtr_q == 2'd3);
        case (state_q)
            S_START:          last_q = (qtr_q == 2'd1);
            S_RSTART, S_STOP: last_q = (qtr_q == 2'd2);
            default:          ;
        endcase
    end

    // Byte being shifted out in the current transmit state.
    always_comb begin
        tx_byte = 8'hFF;
        case (state_q)
            S_ADDR_W: tx_byte = {dev_q, 1'b0};
            S_REG:    tx_byte = reg_q;
            S_WDATA:  tx_byte = wd_q;
            S_ADDR_R: tx_byte = {dev_q, 1'b1};
            default:  ;
        endcase
    end

    // Line levels per state/quarter. Sr starts with an SCL-low quarter so SDA is released
    // while SCL is low; otherwise a slave still holding ACK would see a STOP.
    always_comb begin
        scl_low_c = 1'b0;
        sda_low_c = 1'b0;
        case (state_q)
            S_START:  sda_low_c = (qtr_q == 2'd1);
            S_RSTART: begin
                scl_low_c = (qtr_q == 2'd0);
                sda_low_c = (qtr_q == 2'd2);
            end
            S_STOP: begin
                scl_low_c = (qtr_q == 2'd0);
                sda_low_c = (qtr_q != 2'd2);
            end
            S_ADDR_W, S_REG, S_WDATA, S_ADDR_R: begin
                scl_low_c = !qtr_q[1];
                sda_low_c = !tx_byte[bit_q];
            end
            S_ACK_A, S_ACK_R, S_ACK_D, S_ACK_A2, S_RDATA, S_MNACK: scl_low_c = !qtr_q[1];
            default: ;
        endcase
    end

    // Next-state, counters and datapath.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wd_d    = wd_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        err_d   = err_q;
        nack_d  = nack_q;
        if (state_q == S_IDLE) begin
            qcnt_d = '0;
            qtr_d  = 2'd0;
            bit_d  = 3'd7;
            if (start_in) begin
                rw_d    = rw_in;
                dev_d   = dev_addr_in;
                reg_d   = reg_addr_in;
                wd_d    = wr_data_in;
                err_d   = 1'b0;
                state_d = S_START;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else begin
            if (!stall) qcnt_d = qcnt_q + 1'b1;
            if (sample) begin
                nack_d = i2c_sda;
                if (state_q == S_RDATA) rx_d = {rx_q[6:0], i2c_sda};
            end
            if (tick) begin
                qcnt_d = '0;
                qtr_d  = qtr_q + 2'd1;
                if (last_q) begin
                    qtr_d = 2'd0;
                    // bit counter wraps 0 -> 7, ready for the next byte
                    if (state_q inside {S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA})
                        bit_d = bit_q - 3'd1;
                    case (state_q)
                        S_START:  state_d = S_ADDR_W;
                        S_ADDR_W: if (bit_q == 3'd0) state_d = S_ACK_A;
                        S_REG:    if (bit_q == 3'd0) state_d = S_ACK_R;
                        S_WDATA:  if (bit_q == 3'd0) state_d = S_ACK_D;
                        S_ADDR_R: if (bit_q == 3'd0) state_d = S_ACK_A2;
                        S_RDATA: if (bit_q == 3'd0) begin
                            rd_d    = rx_q;
                            state_d = S_MNACK;
                        end
                        S_ACK_A:  state_d = nack_q ? S_STOP : S_REG;
                        S_ACK_R:  state_d = nack_q ? S_STOP : (rw_q ? S_RSTART : S_WDATA);
                        S_ACK_D:  state_d = S_STOP;
                        S_ACK_A2: state_d = nack_q ? S_STOP : S_RDATA;
                        S_RSTART: state_d = S_ADDR_R;
                        S_MNACK:  state_d = S_STOP;
                        S_STOP:   state_d = S_DONE;
                        default:  state_d = S_IDLE;
                    endcase
                    if (nack_q && (state_q inside {S_ACK_A, S_ACK_R, S_ACK_D, S_ACK_A2}))
                        err_d = 1'b1;
                end
            end
        end
    end

    // State register; SDA is delayed one clock behind SCL so it always moves after SCL falls.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd7;
            rw_q      <= 1'b0;
            dev_q     <= 7'd0;
            reg_q     <= 8'd0;
            wd_q      <= 8'd0;
            rx_q      <= 8'd0;
            rd_q      <= 8'd0;
            err_q     <= 1'b0;
            nack_q    <= 1'b0;
            scl_low_q <= 1'b0;
            sda_pre_q <= 1'b0;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wd_q      <= wd_d;
            rx_q      <= rx_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            nack_q    <= nack_d;
            scl_low_q <= scl_low_c;
            sda_pre_q <= sda_low_c;
            sda_low_q <= sda_pre_q;
        end
    end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// tb_i2c_master_fsm: directed transactions against a behavioural I2C slave on the bus.
// Expected bus tokens and done responses are queued by the stimulus and consumed by monitors.
module tb_i2c_master_fsm;

    localparam int QTR = 4;
    localparam logic [6:0] SLV = 7'h50;
    localparam int T_S = 256, T_P = 257, T_N = 258, T_A = 259;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_in = 1'b0, rw_in = 1'b0;
    logic [6:0] dev_addr_in = 7'd0;
    logic [7:0] reg_addr_in = 8'd0, wr_data_in = 8'd0;
    logic [7:0] rd_data_out;
    logic busy_out, done_out, ack_err_out;
    wire scl_w, sda_w;
    logic slv_sda_low = 1'b0, slv_scl_low = 1'b0;

    pullup (scl_w);
    pullup (sda_w);
    assign scl_w = slv_scl_low ? 1'b0 : 1'bz;
    assign sda_w = slv_sda_low ? 1'b0 : 1'bz;

    i2c_master_fsm #(.QTR_CNT(QTR)) dut (
        .clock_in(clk), .reset_in(rst), .start_in(start_in), .rw_in(rw_in),
        .dev_addr_in(dev_addr_in), .reg_addr_in(reg_addr_in), .wr_data_in(wr_data_in),
        .rd_data_out(rd_data_out), .busy_out(busy_out), .done_out(done_out),
        .ack_err_out(ack_err_out), .i2c_scl(scl_w), .i2c_sda(sda_w)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] rd; logic err; } resp_t;
    resp_t resp_q[$];
    int    bus_q[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic log_tok(input int t);
        if (bus_q.size() == 0) begin
            total++; bad++;
            $display("FAIL bus_extra: got token %0h with nothing expected", t);
        end else begin
            int e;
            e = bus_q.pop_front();
            chk("bus", 16'(t), 16'(e));
        end
    endtask

    // Done monitor: each done pulse must match a queued response.
    always @(negedge clk) begin
        if (!rst && done_out) begin
            if (resp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done: got done=1 want none at cycle %0d", cyc);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("rd_data", 16'(rd_data_out), 16'(r.rd));
                chk("ack_err", 16'(ack_err_out), 16'(r.err));
                chk("busy_at_done", 16'(busy_out), 16'd0);
            end
        end
    end

    // Behavioural slave at SLV: ACKs written bytes, returns rdval on read, logs bus tokens.
    logic       pscl = 1'b1, psda = 1'b1;
    int         bitn = 0;
    logic [7:0] rxsh = 8'd0, txsh = 8'd0, rdval = 8'd0;
    logic       tx_mode = 1'b0, first = 1'b0, addressed = 1'b0, pend_tx = 1'b0;
    logic       addr_ack = 1'b0, stretch_arm = 1'b0, per_done = 1'b0;
    int         stretch_cnt = 0, t_r1 = 0;

    always @(negedge clk) begin
        logic s, d;
        s = scl_w;
        d = sda_w;
        if (rst) begin
            bitn = 0; tx_mode = 1'b0; first = 1'b0; addressed = 1'b0; pend_tx = 1'b0;
            addr_ack = 1'b0; slv_sda_low = 1'b0; slv_scl_low = 1'b0; stretch_cnt = 0;
        end else begin
            if (stretch_cnt > 0) begin
                stretch_cnt--;
                if (stretch_cnt == 0) slv_scl_low = 1'b0;
            end
            if (pscl && s && psda && !d) begin
                log_tok(T_S);
                bitn = 0; first = 1'b1; tx_mode = 1'b0; pend_tx = 1'b0; slv_sda_low = 1'b0;
            end else if (pscl && s && !psda && d) begin
                log_tok(T_P);
                bitn = 0; first = 1'b0; tx_mode = 1'b0; addressed = 1'b0; slv_sda_low = 1'b0;
            end else if (!pscl && s) begin
                if (bitn < 8 && !tx_mode) rxsh = {rxsh[6:0], d};
                if (bitn == 8 && tx_mode) begin
                    log_tok(int'(txsh));
                    log_tok(d ? T_N : T_A);
                end
                if (!per_done && first && bitn == 1) t_r1 = cyc;
                if (!per_done && first && bitn == 2) begin
                    chk("scl_period", 16'(cyc - t_r1), 16'(4 * QTR));
                    per_done = 1'b1;
                end
                bitn++;
            end else if (pscl && !s) begin
                if (bitn == 8) begin
                    if (!tx_mode) begin
                        log_tok(int'(rxsh));
                        addr_ack = first;
                        if (first) begin
                            addressed = (rxsh[7:1] == SLV);
                            pend_tx   = addressed && rxsh[0];
                            first     = 1'b0;
                        end
                        if (addressed) slv_sda_low = 1'b1;
                    end else begin
                        slv_sda_low = 1'b0;
                    end
                end else if (bitn == 9) begin
                    slv_sda_low = 1'b0;
                    bitn = 0;
                    if (tx_mode) tx_mode = 1'b0;
                    else begin
                        tx_mode = pend_tx;
                        pend_tx = 1'b0;
                        if (tx_mode) begin
                            txsh = rdval;
                            slv_sda_low = !txsh[7];
                        end
                    end
                    if (addr_ack && stretch_arm) begin
                        slv_scl_low = 1'b1;
                        stretch_cnt = 40;
                        stretch_arm = 1'b0;
                    end
                    addr_ack = 1'b0;
                end else if (tx_mode && bitn >= 1 && bitn < 8) begin
                    slv_sda_low = !txsh[7 - bitn];
                end
            end
        end
        pscl = s;
        psda = d;
    end

    task automatic push_bus(input int n, input int t0, input int t1, input int t2, input int t3,
                            input int t4, input int t5, input int t6, input int t7);
        int t[8];
        t = '{t0, t1, t2, t3, t4, t5, t6, t7};
        for (int i = 0; i < n; i++) bus_q.push_back(t[i]);
    endtask

    task automatic push_resp(input logic [7:0] rd, input logic err);
        resp_t r;
        r.rd = rd; r.err = err;
        resp_q.push_back(r);
    endtask

    // One transaction; optional mid-transaction start glitch and start-in-DONE-cycle poke.
    task automatic txn(input logic rw, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd,
                       input int glitch_at, input bit start_on_done, output int dur);
        int  t0;
        bit  got;
        @(negedge clk);
        rw_in = rw; dev_addr_in = dev; reg_addr_in = ra; wr_data_in = wd; start_in = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_in = 1'b0;
        chk("busy_rise", 16'(busy_out), 16'd1);
        chk("err_clear", 16'(ack_err_out), 16'd0);
        got = 1'b0;
        dur = 0;
        for (int i = 1; i < 4000; i++) begin
            @(negedge clk);
            if (i == glitch_at) begin
                start_in = 1'b1; rw_in = ~rw; dev_addr_in = 7'h22; wr_data_in = ~wd;
            end else start_in = 1'b0;
            if (done_out) begin
                got = 1'b1;
                dur = cyc - t0;
                if (start_on_done) start_in = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start_in = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL timeout: got no done want done within 4000 cycles");
        end
    endtask

    int dur_base, dur_x;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 16'(busy_out), 16'd0);
        chk("rst_done", 16'(done_out), 16'd0);
        chk("rst_err", 16'(ack_err_out), 16'd0);
        chk("rst_rd", 16'(rd_data_out), 16'd0);
        chk("rst_scl", 16'(scl_w), 16'd1);
        chk("rst_sda", 16'(sda_w), 16'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // write 0x50 / 0x12 / 0xA5
        push_bus(5, T_S, 'hA0, 'h12, 'hA5, T_P, 0, 0, 0);
        push_resp(8'h00, 1'b0);
        txn(1'b0, 7'h50, 8'h12, 8'hA5, 0, 1'b0, dur_base);

        // read 0x50 / 0x12 -> 0x3C
        rdval = 8'h3C;
        push_bus(8, T_S, 'hA0, 'h12, T_S, 'hA1, 'h3C, T_N, T_P);
        push_resp(8'h3C, 1'b0);
        txn(1'b1, 7'h50, 8'h12, 8'h00, 0, 1'b0, dur_x);

        // nobody at 0x22: address NACK, STOP, rd_data held
        push_bus(3, T_S, 'h44, T_P, 0, 0, 0, 0, 0);
        push_resp(8'h3C, 1'b1);
        txn(1'b0, 7'h22, 8'h34, 8'h56, 0, 1'b0, dur_x);

        // start while busy (with changed inputs) is ignored; ack_err cleared on accept
        push_bus(5, T_S, 'hA0, 'h01, 'h5A, T_P, 0, 0, 0);
        push_resp(8'h3C, 1'b0);
        txn(1'b0, 7'h50, 8'h01, 8'h5A, 60, 1'b0, dur_x);

        // start in the DONE cycle is ignored
        push_bus(5, T_S, 'hA0, 'h02, 'h00, T_P, 0, 0, 0);
        push_resp(8'h3C, 1'b0);
        txn(1'b0, 7'h50, 8'h02, 8'h00, 0, 1'b1, dur_x);
        repeat (50) @(negedge clk);
        chk("done_start_ignored", 16'(busy_out), 16'd0);

        // reset in the middle of the register byte
        push_bus(2, T_S, 'hA0, 0, 0, 0, 0, 0, 0);
        rw_in = 1'b0; dev_addr_in = 7'h50; reg_addr_in = 8'h12; wr_data_in = 8'hA5; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_scl", 16'(scl_w), 16'd1);
        chk("abort_sda", 16'(sda_w), 16'd1);
        chk("abort_busy", 16'(busy_out), 16'd0);
        chk("abort_done", 16'(done_out), 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("abort_bus_left", 16'(bus_q.size()), 16'd0);
        repeat (5) @(negedge clk);

        // read after reset
        rdval = 8'hC3;
        push_bus(8, T_S, 'hA0, 'h7F, T_S, 'hA1, 'hC3, T_N, T_P);
        push_resp(8'hC3, 1'b0);
        txn(1'b1, 7'h50, 8'h7F, 8'h00, 0, 1'b0, dur_x);

`ifdef I2C_CLK_STRETCH_EN
        // slave stretches SCL 40 clocks after the address ACK
        push_bus(5, T_S, 'hA0, 'h12, 'hA5, T_P, 0, 0, 0);
        push_resp(8'hC3, 1'b0);
        stretch_arm = 1'b1;
        txn(1'b0, 7'h50, 8'h12, 8'hA5, 0, 1'b0, dur_x);
        chk("stretch_delay", 16'(dur_x - dur_base), 16'(40 - 2 * QTR));
`endif

        repeat (20) @(negedge clk);
        chk("bus_leftover", 16'(bus_q.size()), 16'd0);
        chk("resp_leftover", 16'(resp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
